// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

  localparam bit CNT_WRAP = 1'b0;
  localparam bit CNT_SAT  = 1'b1;

  // Bit positions when tc/ovf are packed into a status register.
  localparam int unsigned TC_BIT  = 0;
  localparam int unsigned OVF_BIT = 1;

  function automatic logic [31:0] max_for_width(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/cnt_next_calc.sv
// Combinational next-count and range-end event for a modulo up/down counter.
module cnt_next_calc #(
  parameter int unsigned          WIDTH    = 4,
  parameter logic [WIDTH-1:0]     MOD_MAX  = '1,
  parameter bit                   SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             en,
  output logic [WIDTH-1:0] next_count,
  output logic             evt
);

  always_comb begin
    next_count = count;
    evt        = 1'b0;
    if (en) begin
      if (count > MOD_MAX) begin
        // Only reachable after X-recovery; snap back to the rail in the step direction.
        evt        = 1'b1;
        next_count = up ? '0 : MOD_MAX;
      end else if (up) begin
        if (count == MOD_MAX) begin
          evt        = 1'b1;
          next_count = SATURATE ? count : '0;
        end else begin
          next_count = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          evt        = 1'b1;
          next_count = SATURATE ? count : MOD_MAX;
        end else begin
          next_count = count - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// WIDTH-bit up/down counter with programmable modulo, wrap/saturate, clear/load,
// registered terminal-count pulse and sticky overflow.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned  WIDTH    = 4,
  parameter logic [31:0]  MOD_MAX  = max_for_width(WIDTH),
  parameter bit           SATURATE = CNT_WRAP,
  parameter logic [31:0]  RST_VAL  = 32'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXV = MOD_MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RSTV = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] nxt;
  logic             evt;
  logic [WIDTH-1:0] load_clamped;

  cnt_next_calc #(
    .WIDTH    (WIDTH),
    .MOD_MAX  (MAXV),
    .SATURATE (SATURATE)
  ) u_next (
    .count      (count),
    .up         (up),
    .en         (en),
    .next_count (nxt),
    .evt        (evt)
  );

  assign load_clamped = (load_val > MAXV) ? MAXV : load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RSTV;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
    end else begin
      // With en=0 the calc passes count through and evt stays low.
      count <= nxt;
      tc    <= evt;
      if (evt) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Drives three counter configurations from shared inputs and checks them against
// an arithmetic reference model plus directed expectations.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       en = 1'b0;
  logic       up = 1'b0;

  logic [3:0] cnt_o [3];
  logic       tc_o  [3];
  logic       ovf_o [3];

  int total = 0;
  int bad   = 0;

  // Per-instance configuration: default wrap, modulo-10 wrap, 0..12 saturating.
  int mx   [3] = '{15, 9, 12};
  bit sat  [3] = '{1'b0, 1'b0, 1'b1};
  int rval [3] = '{0, 0, 5};

  int m_cnt [3];
  bit m_tc  [3];
  bit m_ovf [3];

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));

  mod_updown_counter #(.WIDTH(4), .MOD_MAX(9)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));

  mod_updown_counter #(.WIDTH(4), .MOD_MAX(12), .SATURATE(1'b1), .RST_VAL(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = rval[i];
      m_tc[i]  = 1'b0;
      m_ovf[i] = 1'b0;
    end
  endtask

  // Range 0..M treated as a ring of M+1 values; stepping off either end is the event.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int target;
      bit off_end;
      if (clr) begin
        m_cnt[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > mx[i]) ? mx[i] : int'(load_val);
        m_tc[i]  = 1'b0;
      end else if (en) begin
        target  = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
        off_end = (target < 0) || (target > mx[i]);
        if (off_end && !sat[i]) m_cnt[i] = (target + mx[i] + 1) % (mx[i] + 1);
        else if (!off_end)      m_cnt[i] = target;
        m_tc[i] = off_end;
        if (off_end) m_ovf[i] = 1'b1;
      end else begin
        m_tc[i] = 1'b0;
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.d%0d.count", tag, i), 32'(cnt_o[i]), 32'(m_cnt[i]));
      chk($sformatf("%s.d%0d.tc", tag, i),    32'(tc_o[i]),  32'(m_tc[i]));
      chk($sformatf("%s.d%0d.ovf", tag, i),   32'(ovf_o[i]), 32'(m_ovf[i]));
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    cmp_model(tag);
  endtask

  task automatic drive(input logic c, input logic l, input logic [3:0] lv,
                       input logic e, input logic u);
    clr = c; load = l; load_val = lv; en = e; up = u;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp_model("reset");

    // Release away from the edge, then count up 17 times.
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 1);
    for (int k = 1; k <= 17; k++) begin
      tick("upcount");
      chk($sformatf("upcount.k%0d.count", k), 32'(cnt_o[0]), 32'(k % 16));
      chk($sformatf("upcount.k%0d.tc", k),    32'(tc_o[0]),  32'(k == 16));
      chk($sformatf("upcount.k%0d.ovf", k),   32'(ovf_o[0]), 32'(k >= 16));
    end

    // Modulo-10 down count from 2.
    drive(1, 0, 0, 0, 0); tick("mod10.clr");
    drive(0, 1, 2, 0, 0); tick("mod10.load");
    drive(0, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      int exp_c [4] = '{1, 0, 9, 8};
      tick("mod10");
      chk($sformatf("mod10.k%0d.count", k), 32'(cnt_o[1]), 32'(exp_c[k-1]));
      chk($sformatf("mod10.k%0d.tc", k),    32'(tc_o[1]),  32'(k == 3));
      chk($sformatf("mod10.k%0d.ovf", k),   32'(ovf_o[1]), 32'(k >= 3));
    end

    // Saturate at 12 from 11, then step back down.
    drive(1, 0, 0, 0, 0); tick("sat.clr");
    drive(0, 1, 11, 0, 0); tick("sat.load");
    chk("sat.load.count", 32'(cnt_o[2]), 32'd11);
    drive(0, 0, 0, 1, 1);
    for (int k = 1; k <= 3; k++) begin
      tick("sat");
      chk($sformatf("sat.k%0d.count", k), 32'(cnt_o[2]), 32'd12);
      chk($sformatf("sat.k%0d.tc", k),    32'(tc_o[2]),  32'(k >= 2));
      chk($sformatf("sat.k%0d.ovf", k),   32'(ovf_o[2]), 32'(k >= 2));
    end
    drive(0, 0, 0, 1, 0); tick("sat.down");
    chk("sat.down.count", 32'(cnt_o[2]), 32'd11);
    chk("sat.down.tc",    32'(tc_o[2]),  32'd0);

    // Priority: clr over load over en.
    drive(0, 1, 7, 0, 0); tick("prio.load7");
    drive(1, 1, 3, 1, 1); tick("prio.clr");
    chk("prio.clr.count", 32'(cnt_o[0]), 32'd0);
    chk("prio.clr.ovf",   32'(ovf_o[2]), 32'd0);
    drive(0, 1, 5, 1, 1); tick("prio.load");
    chk("prio.load.count", 32'(cnt_o[0]), 32'd5);

    // Load clamp with ovf already set on the modulo-10 instance.
    drive(0, 1, 0, 0, 0); tick("clamp.load0");
    drive(0, 0, 0, 1, 0); tick("clamp.wrap");
    chk("clamp.pre.ovf", 32'(ovf_o[1]), 32'd1);
    drive(0, 1, 15, 0, 0); tick("clamp");
    chk("clamp.d1.count", 32'(cnt_o[1]), 32'd9);
    chk("clamp.d2.count", 32'(cnt_o[2]), 32'd12);
    chk("clamp.d1.tc",    32'(tc_o[1]),  32'd0);
    chk("clamp.d1.ovf",   32'(ovf_o[1]), 32'd1);

    // Asynchronous reset between edges.
    drive(0, 1, 6, 0, 0); tick("areset.load6");
    drive(0, 0, 0, 1, 1);
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    cmp_model("areset.now");
    chk("areset.d2.count", 32'(cnt_o[2]), 32'd5);
    rst_n = 1'b1;
    tick("areset.resume");
    chk("areset.resume.count", 32'(cnt_o[0]), 32'd1);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(15) == 0), ($urandom_range(7) == 0), 4'($urandom_range(15)),
            ($urandom_range(3) != 0), 1'($urandom_range(1)));
      tick($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
